xor_decrypt: RTL
================

XOR_DECRYPT -- requirements
Module: xor_decrypt

Interface
REQ-001 SHALL have parameter LANE_W, default 32: bits decoded per cycle; legal values 8, 16, 32, 64, 128, 256.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port valid_in, input, 1 bit: upstream block valid.
REQ-005 SHALL have port ready, output, 1 bit: block can accept a new input.
REQ-006 SHALL have port key, input, 8 bits: decryption key; sampled only on an accepted input.
REQ-007 SHALL have port code, input, 256 bits: ciphertext; sampled only on an accepted input.
REQ-008 SHALL have port code_out, output, 256 bits: recovered plaintext.
REQ-009 SHALL have port valid_out, output, 1 bit: code_out holds a complete result.
REQ-010 SHALL have port ready_in, input, 1 bit: downstream accepts code_out.

Function
REQ-011 SHALL invert the team encryption mapping: p'[0:7] = p[0:7]^key, p'[8:255] = p[8:255], then c[0] = p'[0] and c[i] = c[i-1]^p'[i] (bitwise prefix XOR).
REQ-012 SHALL compute the decode as d[0] = c[0] and d[i] = c[i]^c[i-1] for i>0, then code_out[7:0] = d[7:0]^key and code_out[255:8] = d[255:8].
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE; ready = 1 only in IDLE.
REQ-014 SHALL accept an input when valid_in && ready: latch code and key, clear the lane counter, and go IDLE->BUSY.
REQ-015 SHALL, in BUSY, write lane k (bits LANE_W*k+LANE_W-1 : LANE_W*k) of code_out each cycle, with k counting 0 to N-1 and N = 256/LANE_W.
REQ-016 SHALL use the latched bit c[LANE_W*k-1] as the lane-boundary bit for lane k>0.
REQ-017 SHALL go BUSY->DONE at the edge that writes lane N-1; valid_out = 1 exactly in DONE.
REQ-018 SHALL give latency N cycles from the accepting edge to valid_out high (8 cycles at default).
REQ-019 SHALL stay in DONE with code_out and valid_out stable while ready_in = 0.
REQ-020 SHALL go DONE->IDLE on the edge where ready_in = 1; valid_out low and ready high the next cycle.
REQ-021 SHALL make a new acceptance impossible in the same cycle as the output handshake, giving a back-to-back throughput of one block per N+2 cycles.
REQ-022 SHALL ignore valid_in while in BUSY or DONE; changes to code or key after acceptance SHALL NOT affect the result.
REQ-023 SHALL leave code_out lanes not yet written during BUSY holding their prior values; they carry no meaning until valid_out.
REQ-024 SHALL, for LANE_W = 256, go BUSY->DONE after the single BUSY cycle.

Reset
REQ-025 SHALL, while rst = 1, force state = IDLE, lane counter = 0, code_out = 0, valid_out = 0, ready = 1, and clear the latched code and key, independent of clk.
REQ-026 SHALL abort any in-flight block on rst assertion mid-BUSY or mid-DONE, with no output produced.
REQ-027 SHALL accept a first valid_in on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, when XOR_DECRYPT_CNT_EN is defined, add output blk_cnt, 16 bits: the count of completed output handshakes (DONE && ready_in).
REQ-029 SHALL increment blk_cnt by 1 per handshake, saturate it at 16'hFFFF, and reset it to 0 on rst.
REQ-030 SHALL, when XOR_DECRYPT_CNT_EN is undefined, omit the blk_cnt port and counter with all other behaviour identical.

Verification
REQ-031 Basic decode: key=8'h5A, code=256'h36, ready_in=1 -> valid_out rises 8 cycles after acceptance; code_out=256'h0; blk_cnt=1 (if enabled).
REQ-032 All-ones input: key=8'h00, code=all ones -> code_out=256'h1.
REQ-033 Backpressure and input isolation: ready_in=0 for 5 cycles in DONE, and code/key toggle after acceptance -> code_out and valid_out held constant; IDLE entered one edge after ready_in=1.
REQ-034 Reset abort: assert rst 3 cycles into BUSY -> code_out=0, valid_out=0, ready=1 immediately; the next block with key=8'h5A, code=256'h36 decodes to 0.
REQ-035 Random round-trip: 1000 random key/plaintext pairs encrypted by a reference model, run with LANE_W=8, 32 and 256 -> every code_out equals its plaintext; a valid_in pulse during BUSY is ignored.
REQ-036 Counter saturation: with XOR_DECRYPT_CNT_EN defined, 65537 handshakes -> blk_cnt=16'hFFFF.

Source files
------------

// File: rtl/xor_decrypt.sv
// XOR prefix-chain decryptor: latches one 256-bit block and recovers it LANE_W bits per cycle.
// Optional completed-handshake counter output blk_cnt enabled by defining XOR_DECRYPT_CNT_EN.
module xor_decrypt #(
  parameter int LANE_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  output logic         ready,
  input  logic [7:0]   key,
  input  logic [255:0] code,
  output logic [255:0] code_out,
  output logic         valid_out,
  input  logic         ready_in
`ifdef XOR_DECRYPT_CNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  localparam int N     = 256 / LANE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   lane_cnt_reg;
  logic [255:0]       code_reg;
  logic [7:0]         key_reg;
  logic [255:0]       decoded;
  logic [N-1:0]       lane_we;
  logic               accept;
  logic               last_lane;
  logic               handshake;

  assign accept    = valid_in && ready;
  assign last_lane = (lane_cnt_reg == CNT_W'(N - 1));
  assign handshake = (state_reg == DONE) && ready_in;

  // Shifting the latched word by one makes c[LANE_W*k-1] the boundary bit of lane k automatically.
  assign decoded = code_reg ^ {code_reg[254:0], 1'b0} ^ {248'b0, key_reg};

  for (genvar gi = 0; gi < N; gi++) begin : g_lane_we
    assign lane_we[gi] = (state_reg == BUSY) && (lane_cnt_reg == CNT_W'(gi));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_lane) state_next = DONE;
      DONE:    if (ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready     = (state_reg == IDLE);
    valid_out = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_reg <= '0;
      code_reg     <= '0;
      key_reg      <= '0;
    end else if (accept) begin
      lane_cnt_reg <= '0;
      code_reg     <= code;
      key_reg      <= key;
    end else if (state_reg == BUSY) begin
      lane_cnt_reg <= lane_cnt_reg + 1'b1;
    end
  end

  // Unwritten lanes keep their previous contents until their turn comes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_out <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (lane_we[i]) begin
          code_out[i*LANE_W +: LANE_W] <= decoded[i*LANE_W +: LANE_W];
        end
      end
    end
  end

`ifdef XOR_DECRYPT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (handshake && (blk_cnt != 16'hFFFF)) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule
